// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU request sequencer.
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Quiet NaN returned when the watchdog aborts an operation.
  localparam logic [15:0] QNAN16 = 16'h7E00;

  // Queued request, 34 bits: {op, x, y}.
  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] x;
    logic [15:0] y;
  } fpu_req_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO: DEPTH entries of {op, x, y}, occupancy-based full/empty.
module fpu_req_fifo
  import fpu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  fpu_req_t                         push_data,
  input  logic                             pop,
  output fpu_req_t                         head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fpu_req_t          r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign head    = r_mem[r_rd_ptr];
  assign count   = r_count;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Queues half-precision requests and launches them one at a time on
// fpu_16bit, returning result/flags on a valid/ready response port.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [15:0]                  req_x,
  input  logic [15:0]                  req_y,
  input  logic [1:0]                   req_op,
  output logic [15:0]                  fpu_x,
  output logic [15:0]                  fpu_y,
  output logic [1:0]                   fpu_op,
  output logic                         fpu_start,
  input  logic                         fpu_done,
  input  logic [15:0]                  fpu_result,
  input  logic [1:0]                   fpu_ofuf,
  input  logic [2:0]                   fpu_comp,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [15:0]                  rsp_result,
  output logic [1:0]                   rsp_ofuf,
  output logic [2:0]                   rsp_comp,
  output logic                         rsp_timeout,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  seq_state_t  r_state;
  logic        r_start;
  logic [15:0] r_fpu_x;
  logic [15:0] r_fpu_y;
  logic [1:0]  r_fpu_op;
  logic [15:0] r_wd;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_result;
  logic [1:0]  r_rsp_ofuf;
  logic [2:0]  r_rsp_comp;
  logic        r_rsp_timeout;

  fpu_req_t    w_push_data;
  fpu_req_t    w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;

  assign w_push_data = {req_op, req_x, req_y};
  assign w_pop       = (r_state == ST_IDLE) & ~w_empty;

  fpu_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (count)
  );

  // Reset is OR-ed in so the FPU is held in reset together with this block.
  assign fpu_start   = reset | r_start;
  assign req_ready   = ~w_full;
  assign busy        = (r_state != ST_IDLE);
  assign fpu_x       = r_fpu_x;
  assign fpu_y       = r_fpu_y;
  assign fpu_op      = r_fpu_op;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_ofuf    = r_rsp_ofuf;
  assign rsp_comp    = r_rsp_comp;
  assign rsp_timeout = r_rsp_timeout;

  // Issue FSM with watchdog and registered response payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_start       <= 1'b0;
      r_fpu_x       <= '0;
      r_fpu_y       <= '0;
      r_fpu_op      <= '0;
      r_wd          <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_ofuf    <= '0;
      r_rsp_comp    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_fpu_x  <= w_head.x;
            r_fpu_y  <= w_head.y;
            r_fpu_op <= w_head.op;
            r_start  <= 1'b1;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          r_start <= 1'b0;
          r_state <= ST_ARM;
        end
        // done may still be high from the previous operation; ignore it here.
        ST_ARM: begin
          r_wd    <= '0;
          r_state <= ST_WAIT;
        end
        // done takes priority over a watchdog expiry in the same cycle.
        ST_WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (fpu_done) begin
            r_rsp_result  <= fpu_result;
            r_rsp_ofuf    <= fpu_ofuf;
            r_rsp_comp    <= fpu_comp;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else if (r_wd == WD_LIMIT) begin
            r_rsp_result  <= QNAN16;
            r_rsp_ofuf    <= '0;
            r_rsp_comp    <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_start     <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a behavioural FPU stub.
module tb_fpu_op_sequencer;
  import fpu_seq_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_x;
  logic [15:0]   req_y;
  logic [1:0]    req_op;
  logic [15:0]   fpu_x;
  logic [15:0]   fpu_y;
  logic [1:0]    fpu_op;
  logic          fpu_start;
  logic          fpu_done;
  logic [15:0]   fpu_result;
  logic [1:0]    fpu_ofuf;
  logic [2:0]    fpu_comp;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_result;
  logic [1:0]    rsp_ofuf;
  logic [2:0]    rsp_comp;
  logic          rsp_timeout;
  logic          busy;
  logic [CW-1:0] count;

  int unsigned vectors;
  int unsigned miscompares;

  // 0 = normal (done 3 cycles after start), 1 = stale done, 2 = hang
  int unsigned stub_mode;
  int unsigned stub_cnt;
  logic        stub_active;

  fpu_op_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_op      (req_op),
    .fpu_x       (fpu_x),
    .fpu_y       (fpu_y),
    .fpu_op      (fpu_op),
    .fpu_start   (fpu_start),
    .fpu_done    (fpu_done),
    .fpu_result  (fpu_result),
    .fpu_ofuf    (fpu_ofuf),
    .fpu_comp    (fpu_comp),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_ofuf    (rsp_ofuf),
    .rsp_comp    (rsp_comp),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed binary16 results for the directed operands; x+y otherwise.
  function automatic logic [15:0] stub_res(input logic [1:0] op, input logic [15:0] x,
                                           input logic [15:0] y);
    if (op == OP_ADD && x == 16'h0F00 && y == 16'h0B80) return 16'h1160;
    if (op == OP_SUB && x == 16'hD98D && y == 16'h4F08) return 16'hDA6E;
    if (op == OP_MUL && x == 16'h4F00 && y == 16'h0B80) return 16'h1E90;
    if (op == OP_DIV && x == 16'h118D && y == 16'hEF08) return 16'h8000;
    return x + y;
  endfunction

  // FPU stub: start-by-reset, holds done high until the next start.
  always @(posedge clk) begin
    if (fpu_start) begin
      stub_cnt    <= 0;
      stub_active <= (stub_mode != 2);
      fpu_done    <= (stub_mode == 1);
    end else if (stub_active) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_mode == 1) begin
        if (stub_cnt == 0) fpu_done <= 1'b0;
        if (stub_cnt == 6) begin
          fpu_done    <= 1'b1;
          fpu_result  <= 16'h1234;
          stub_active <= 1'b0;
        end
      end else if (stub_cnt == 2) begin
        fpu_done    <= 1'b1;
        fpu_result  <= stub_res(fpu_op, fpu_x, fpu_y);
        fpu_ofuf    <= (fpu_op == OP_DIV && fpu_x == 16'h118D && fpu_y == 16'hEF08) ? 2'b01 : 2'b00;
        fpu_comp    <= (fpu_x > fpu_y) ? 3'b100 : ((fpu_x == fpu_y) ? 3'b010 : 3'b001);
        stub_active <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; push is taken at the following posedge.
  task automatic push1(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at a negedge with rsp_ready=1; returns at the negedge after the handshake.
  task automatic get_rsp(output logic [15:0] r, output logic [1:0] of, output logic [2:0] c,
                         output logic to, output logic ok);
    ok = 1'b0;
    r = '0; of = '0; c = '0; to = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (rsp_valid) begin
        r  = rsp_result;
        of = rsp_ofuf;
        c  = rsp_comp;
        to = rsp_timeout;
        ok = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (fpu_start) ok = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  logic [15:0] r;
  logic [1:0]  of;
  logic [2:0]  c;
  logic        to;
  logic        ok;
  int unsigned seen;
  logic [15:0] qx   [5] = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
  logic [15:0] qexp [5] = '{16'h0121, 16'h0122, 16'h0123, 16'h0124, 16'h0125};

  initial begin
    vectors     = 0;
    miscompares = 0;
    stub_mode   = 0;
    stub_cnt    = 0;
    stub_active = 1'b0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_x       = '0;
    req_y       = '0;
    req_op      = '0;
    rsp_ready   = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_fpu_start", fpu_start, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_fpu_x", fpu_x, 0);
    check("rst_rsp_result", rsp_result, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_fpu_start", fpu_start, 0);

    // Chain add/sub/mul in order
    push1(OP_ADD, 16'h0F00, 16'h0B80);
    push1(OP_SUB, 16'hD98D, 16'h4F08);
    push1(OP_MUL, 16'h4F00, 16'h0B80);
    get_rsp(r, of, c, to, ok);
    check("add_arrive", ok, 1);
    check("add_result", r, 16'h1160);
    check("add_timeout", to, 0);
    check("add_comp", c, 3'b100);
    get_rsp(r, of, c, to, ok);
    check("sub_result", r, 16'hDA6E);
    get_rsp(r, of, c, to, ok);
    check("mul_result", r, 16'h1E90);

    // Queue fill with responses blocked
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push1(OP_ADD, qx[i], 16'h0020);
    check("fill_count", count, 4);
    check("fill_req_ready", req_ready, 0);
    check("fill_busy", busy, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(r, of, c, to, ok);
      check("fill_arrive", ok, 1);
      check("fill_result", r, qexp[i]);
    end
    check("fill_drained", count, 0);

    // Watchdog expiry, then a normal request
    stub_mode = 2;
    rsp_ready = 1'b0;
    push1(OP_ADD, 16'h1111, 16'h2222);
    wait_start(ok);
    check("wd_start_seen", ok, 1);
    seen = 0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = k;
    end
    check("wd_latency", seen, 11);
    check("wd_result", rsp_result, 16'h7E00);
    check("wd_timeout", rsp_timeout, 1);
    check("wd_ofuf", rsp_ofuf, 0);
    check("wd_comp", rsp_comp, 0);
    push1(OP_SUB, 16'h0300, 16'h0100);
    check("wd_held", rsp_result, 16'h7E00);
    stub_mode = 0;
    rsp_ready = 1'b1;
    get_rsp(r, of, c, to, ok);
    check("wd_rsp_timeout", to, 1);
    get_rsp(r, of, c, to, ok);
    check("post_wd_arrive", ok, 1);
    check("post_wd_result", r, 16'h0400);
    check("post_wd_timeout", to, 0);

    // Stale done held through START/ARM must not be captured
    stub_mode = 1;
    push1(OP_ADD, 16'h0AAA, 16'h0555);
    get_rsp(r, of, c, to, ok);
    check("stale_arrive", ok, 1);
    check("stale_result", r, 16'h1234);
    check("stale_timeout", to, 0);
    stub_mode = 0;

    // Underflow flags pass through
    push1(OP_DIV, 16'h118D, 16'hEF08);
    get_rsp(r, of, c, to, ok);
    check("uf_result", r, 16'h8000);
    check("uf_ofuf", of, 2'b01);
    check("uf_timeout", to, 0);
    check("uf_comp", c, 3'b001);

    // Reset during WAIT with two queued requests
    stub_mode = 2;
    push1(OP_ADD, 16'h0001, 16'h0002);
    push1(OP_ADD, 16'h0003, 16'h0004);
    push1(OP_ADD, 16'h0005, 16'h0006);
    check("mid_count", count, 2);
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_fpu_start", fpu_start, 1);
    check("mid_rst_count", count, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    @(negedge clk);
    reset     = 1'b0;
    stub_mode = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("post_rst_no_rsp", seen, 0);
    check("post_rst_idle", busy, 0);
    push1(OP_ADD, 16'h0F00, 16'h0B80);
    wait_start(ok);
    check("post_rst_start", ok, 1);
    check("post_rst_fpu_x", fpu_x, 16'h0F00);
    check("post_rst_fpu_y", fpu_y, 16'h0B80);
    check("post_rst_fpu_op", fpu_op, OP_ADD);
    get_rsp(r, of, c, to, ok);
    check("post_rst_arrive", ok, 1);
    check("post_rst_result", r, 16'h1160);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
